// File: rtl/sms_audio_mixer_tdm.sv
// Time-multiplexed NCH-channel stereo mixer with saturation; aud_valid arrives NCH+2 cycles after sample_stb.
// No backpressure: a strobe while busy is dropped and latched in the sticky overrun flag.
module sms_audio_mixer_tdm #(
    parameter int NCH    = 4,
    parameter int IN_W   = 16,
    parameter int OUT_W  = 18,
    parameter int GAIN_W = 2
) (
    input  logic                    MCLK,
    input  logic                    ext_reset,
    input  logic                    sample_stb,
    input  logic [NCH*IN_W-1:0]     ch_data,
    input  logic [NCH-1:0]          ch_signed,
    input  logic [NCH*GAIN_W-1:0]   ch_gain,
    input  logic [NCH-1:0]          ch_mute,
    input  logic [NCH-1:0]          ch_pan_l,
    input  logic [NCH-1:0]          ch_pan_r,
    input  logic                    clr_overrun,
    output logic [OUT_W-1:0]        aud_l,
    output logic [OUT_W-1:0]        aud_r,
    output logic                    aud_valid,
    output logic                    busy,
    output logic                    overrun
);

    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int ACC_W = IN_W + 1 + (2**GAIN_W - 1) + $clog2(NCH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, SAT} state_t;

    state_t state, state_nxt;

    logic [NCH*IN_W-1:0]   cap_data;
    logic [NCH-1:0]        cap_signed;
    logic [NCH*GAIN_W-1:0] cap_gain;
    logic [NCH-1:0]        cap_mute;
    logic [NCH-1:0]        cap_pan_l;
    logic [NCH-1:0]        cap_pan_r;
    logic [IDX_W-1:0]      idx;

    logic signed [ACC_W-1:0] acc_l;
    logic signed [ACC_W-1:0] acc_r;

    logic [IN_W-1:0]         cur_raw;
    logic [GAIN_W-1:0]       cur_gain;
    logic signed [ACC_W-1:0] cur_ext;
    logic signed [ACC_W-1:0] cur_term;
    logic                    add_l;
    logic                    add_r;

    function automatic logic [OUT_W-1:0] clamp(input logic signed [ACC_W-1:0] a);
        if (a > SAT_MAX)
            return SAT_MAX[OUT_W-1:0];
        else if (a < SAT_MIN)
            return SAT_MIN[OUT_W-1:0];
        else
            return a[OUT_W-1:0];
    endfunction

    always_ff @(posedge MCLK) begin
        if (ext_reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sample_stb) state_nxt = ACCUM;
            ACCUM:   if (idx == LAST_IDX) state_nxt = SAT;
            SAT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Current channel term, extended to the full accumulator width before shifting so it never wraps.
    always_comb begin
        cur_raw  = cap_data[idx*IN_W +: IN_W];
        cur_gain = cap_gain[idx*GAIN_W +: GAIN_W];
        if (cap_signed[idx])
            cur_ext = {{(ACC_W-IN_W){cur_raw[IN_W-1]}}, cur_raw};
        else
            cur_ext = {{(ACC_W-IN_W){1'b0}}, cur_raw};
        cur_term = cur_ext << cur_gain;
        add_l    = !cap_mute[idx] && cap_pan_l[idx];
        add_r    = !cap_mute[idx] && cap_pan_r[idx];
    end

    always_ff @(posedge MCLK) begin
        if (ext_reset) begin
            cap_data   <= '0;
            cap_signed <= '0;
            cap_gain   <= '0;
            cap_mute   <= '0;
            cap_pan_l  <= '0;
            cap_pan_r  <= '0;
            idx        <= '0;
            acc_l      <= '0;
            acc_r      <= '0;
            aud_l      <= '0;
            aud_r      <= '0;
            aud_valid  <= 1'b0;
        end else begin
            aud_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_stb) begin
                        cap_data   <= ch_data;
                        cap_signed <= ch_signed;
                        cap_gain   <= ch_gain;
                        cap_mute   <= ch_mute;
                        cap_pan_l  <= ch_pan_l;
                        cap_pan_r  <= ch_pan_r;
                        idx        <= '0;
                        acc_l      <= '0;
                        acc_r      <= '0;
                    end
                end
                ACCUM: begin
                    if (add_l) acc_l <= acc_l + cur_term;
                    if (add_r) acc_r <= acc_r + cur_term;
                    if (idx != LAST_IDX) idx <= idx + 1'b1;
                end
                SAT: begin
                    aud_l     <= clamp(acc_l);
                    aud_r     <= clamp(acc_r);
                    aud_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A new overrun event takes priority over a simultaneous clear.
    always_ff @(posedge MCLK) begin
        if (ext_reset)
            overrun <= 1'b0;
        else if (sample_stb && busy)
            overrun <= 1'b1;
        else if (clr_overrun)
            overrun <= 1'b0;
    end

endmodule
